muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS pipeline's execute stage.
- Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- HI/LO are read combinationally by the MFHI/MFLO datapath, whose result is written back to the general register file.
- Busy drives the hazard unit, which stalls any following muldiv or MFHI/MFLO instruction.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Optional accumulate ops (MADD/MADDU/MSUB) are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAXC =
        (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      op_q;
    logic [31:0]     a_q, b_q;
    logic [31:0]     hi_q, lo_q;
    logic            busy_q, done_q;

    function automatic logic is_mul(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    logic [63:0] prod_s, prod_u;
    logic        sdiv, a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic [63:0] res;
    logic        res_wr;

    // Sign-extended 64-bit product keeps only the low 64 bits: exact signed result.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
    end

    // Divide on magnitudes then restore signs; this also covers 0x80000000 / -1.
    always_comb begin
        sdiv   = (op_q == OP_DIV);
        a_neg  = sdiv & a_q[31];
        b_neg  = sdiv & b_q[31];
        b_zero = (b_q == 32'd0);
        a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
        q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
        r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
        quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        res    = {hi_q, lo_q};
        res_wr = 1'b1;
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV, OP_DIVU: begin
                res    = {rem, quo};
                res_wr = ~b_zero;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  res = {hi_q, lo_q} + prod_s;
            OP_MADDU: res = {hi_q, lo_q} + prod_u;
            OP_MSUB:  res = {hi_q, lo_q} - prod_s;
`endif
            default:  res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (is_mul(Op) || is_div(Op)) begin
                            op_q    <= Op;
                            a_q     <= A;
                            b_q     <= B;
                            cnt_q   <= is_div(Op) ? CW'(DIV_CYCLES)
                                                  : CW'(MUL_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else if (Op == OP_MTHI) begin
                            hi_q <= A;
                        end else if (Op == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(1)) begin
                        if (res_wr) begin
                            hi_q <= res[63:32];
                            lo_q <= res[31:0];
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random ops against an arithmetic model of HI/LO.
module tb_muldiv_unit;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  Op = '0;
    logic [31:0] A = '0, B = '0;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    muldiv_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mhi = '0, mlo = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [3:0] op);
        if (op <= 4'd1) return MULC;
        if (op <= 4'd3) return DIVC;
`ifdef MULDIV_MADD_EN
        if (op >= 4'd6 && op <= 4'd8) return MULC;
`endif
        return 0;
    endfunction

    // Reference model: plain 64-bit / int arithmetic on the architectural state.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, acc;
        int              ia, ib;
        logic [63:0]     r;
        bit              push;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {mhi, mlo};
        ia = a;
        ib = b;
        push = 1'b0;
        r = acc;
        case (op)
            4'd0: begin r = sa * sb; push = 1; end
            4'd1: begin r = ua * ub; push = 1; end
            4'd2: begin
                push = 1;
                if (b == 0) r = acc;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    r = {32'd0, 32'h80000000};
                else r = {32'(ia % ib), 32'(ia / ib)};
            end
            4'd3: begin
                push = 1;
                if (b != 0) r = {a % b, a / b};
            end
            4'd4: mhi = a;
            4'd5: mlo = a;
`ifdef MULDIV_MADD_EN
            4'd6: begin r = acc + 64'(sa * sb); push = 1; end
            4'd7: begin r = acc + ua * ub; push = 1; end
            4'd8: begin r = acc - 64'(sa * sb); push = 1; end
`endif
            default: ;
        endcase
        if (push) begin
            {mhi, mlo} = r;
            sbq.push_back('{hi: mhi, lo: mlo, cyc: cyc + 1 + lat(op)});
        end
    endtask

    // Called just after a falling edge; the op is sampled at the next rising edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit use_model);
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        if (use_model) model(op, a, b);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op = 4'($urandom);
        A = $urandom;
        B = $urandom;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge Clk);
        drive(op, a, b, 1'b1);
    endtask

    task automatic wait_idle(input string nm, input int exp_busy);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (!Busy) break;
            n++;
        end
        chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({nm, "_hi"}, HI, mhi);
        chk({nm, "_lo"}, LO, mlo);
    endtask

    task automatic run(input string nm, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_idle(nm, lat(op));
    endtask

    always @(negedge Clk) begin
        if (Rst && Done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_hi", HI, e.hi);
                chk("sb_lo", LO, e.lo);
                chk("sb_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        bit          seen;

        #1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;

        run("mult", 4'd0, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi_k", HI, 32'hFFFFFFFF);
        chk("mult_lo_k", LO, 32'hFFFFFFFA);
        run("multu", 4'd1, 32'hFFFFFFFE, 32'd3);
        chk("multu_hi_k", HI, 32'h00000002);
        chk("multu_lo_k", LO, 32'hFFFFFFFA);

        run("div_neg", 4'd2, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_lo_k", LO, 32'hFFFFFFFD);
        chk("div_neg_hi_k", HI, 32'hFFFFFFFF);
        run("divu", 4'd3, 32'd7, 32'd2);
        chk("divu_lo_k", LO, 32'd3);
        chk("divu_hi_k", HI, 32'd1);
        run("div_ovf", 4'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo_k", LO, 32'h80000000);
        chk("div_ovf_hi_k", HI, 32'd0);

        run("mthi", 4'd4, 32'h1234, 32'd0);
        run("mtlo", 4'd5, 32'h5678, 32'd0);
        issue(4'd2, 32'd5, 32'd0);
        @(negedge Clk);
        drive(4'd5, 32'h9, 32'd0, 1'b0);
        wait_idle("div0", DIVC - 1);
        chk("div0_hi_k", HI, 32'h1234);
        chk("div0_lo_k", LO, 32'h5678);

        // Mid-cycle asynchronous reset.
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        mhi = '0;
        mlo = '0;
        @(negedge Clk);
        Rst = 1'b1;

        // Abort an in-flight multiply.
        run("pre_abort", 4'd5, 32'hAAAA, 32'd0);
        @(negedge Clk);
        drive(4'd0, 32'd3, 32'd4, 1'b0);
        @(negedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        mhi = '0;
        mlo = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        repeat (MULC + 2) @(negedge Clk);

        // Back-to-back: second op issued in the Done cycle of the first.
        issue(4'd0, 32'd3, 32'd4);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_done_seen", 32'(seen), 32'd1);
        chk("b2b_first_lo", LO, 32'd12);
        drive(4'd1, 32'd5, 32'd6, 1'b1);
        wait_idle("b2b", MULC);
        chk("b2b_second_lo", LO, 32'd30);

`ifdef MULDIV_MADD_EN
        run("madd_hi0", 4'd4, 32'd0, 32'd0);
        run("madd_lo", 4'd5, 32'hFFFFFFFF, 32'd0);
        run("maddu", 4'd7, 32'd1, 32'd1);
        chk("maddu_hi_k", HI, 32'd1);
        chk("maddu_lo_k", LO, 32'd0);
        run("msub", 4'd8, 32'd1, 32'd2);
        chk("msub_hi_k", HI, 32'd0);
        chk("msub_lo_k", LO, 32'hFFFFFFFE);
`endif

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run("rand", rop, ra, rb);
        end

        repeat (3) @(negedge Clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
